// File: rtl/wb_buffer_pkg.sv
// Shared writeback-buffer definitions. The decode-stage bypass uses the same
// entry layout.
package wb_buffer_pkg;
    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_RD   = 4;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_buffer_if.sv
// Bus between the pipeline result lanes, the register file write and read
// ports, and the writeback buffer.
interface wb_buffer_if
    import wb_buffer_pkg::*;
#(
    parameter int XLEN = wb_buffer_pkg::XLEN,
    parameter int AW   = wb_buffer_pkg::AW
);
    logic                   in0_valid;
    logic [AW-1:0]          in0_rd;
    logic [XLEN-1:0]        in0_data;
    logic                   in1_valid;
    logic [AW-1:0]          in1_rd;
    logic [XLEN-1:0]        in1_data;
    logic                   in_ready;
    logic                   wb_hold;
    logic                   we1;
    logic [AW-1:0]          waddr1;
    logic [XLEN-1:0]        wdata1;
    logic                   we2;
    logic [AW-1:0]          waddr2;
    logic [XLEN-1:0]        wdata2;
    logic [NUM_RD*AW-1:0]   raddr;
    logic [NUM_RD-1:0]      byp_hit;
    logic [NUM_RD*XLEN-1:0] byp_data;

    modport master (
        output in0_valid, in0_rd, in0_data, in1_valid, in1_rd, in1_data,
        output wb_hold, raddr,
        input  in_ready, we1, waddr1, wdata1, we2, waddr2, wdata2,
        input  byp_hit, byp_data
    );

    modport slave (
        input  in0_valid, in0_rd, in0_data, in1_valid, in1_rd, in1_data,
        input  wb_hold, raddr,
        output in_ready, we1, waddr1, wdata1, we2, waddr2, wdata2,
        output byp_hit, byp_data
    );
endinterface

// File: rtl/wb_bypass_lookup.sv
// Newest-wins search of the buffered entries for one read address.
// Scans from the head (oldest) so the last match found is the youngest.
module wb_bypass_lookup
    import wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = wb_buffer_pkg::XLEN,
    parameter int AW    = wb_buffer_pkg::AW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]           occ,
    input  logic [DEPTH-1:0][AW-1:0]   rd_q,
    input  logic [DEPTH-1:0][XLEN-1:0] data_q,
    input  logic [PW-1:0]              head,
    input  logic [AW-1:0]              raddr,
    output logic                       hit,
    output logic [XLEN-1:0]            data
);
    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (occ[idx] && (rd_q[idx] == raddr) && (raddr != AW'(ZERO_REG))) begin
                hit  = 1'b1;
                data = data_q[idx];
            end
        end
    end
endmodule

// File: rtl/wb_buffer.sv
// Dual-lane in-order writeback FIFO feeding the 2-write register file, with
// same-address pair squashing and a four-port newest-wins bypass.
module wb_buffer
    import wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = wb_buffer_pkg::XLEN,
    parameter int AW    = wb_buffer_pkg::AW
) (
    input  logic      clk,
    input  logic      rst,
    wb_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0]   rd_q;
    logic [DEPTH-1:0][XLEN-1:0] data_q;
    logic [PW-1:0]              wptr, rptr, wptr1, rptr1;
    logic [CW-1:0]              count;
    logic [DEPTH-1:0]           occ;
    logic                       push0, push1, drain_en, pop1, pop2, collide;
    logic [1:0]                 npush, npop;

    assign bus.in_ready = !rst && (count <= CW'(DEPTH - 2));

    // x0 results are acknowledged but never stored.
    assign push0 = bus.in_ready && bus.in0_valid && (bus.in0_rd != AW'(ZERO_REG));
    assign push1 = bus.in_ready && bus.in1_valid && (bus.in1_rd != AW'(ZERO_REG));
    assign npush = {1'b0, push0} + {1'b0, push1};

    assign wptr1 = wptr + PW'(1);
    assign rptr1 = rptr + PW'(1);

    // Gating on rst keeps the register file from capturing entries being discarded.
    assign drain_en = !bus.wb_hold && !rst;
    assign pop1     = drain_en && (count >= CW'(1));
    assign pop2     = drain_en && (count >= CW'(2));
    assign collide  = pop2 && (rd_q[rptr] == rd_q[rptr1]);
    assign npop     = {1'b0, pop1} + {1'b0, pop2};

    assign bus.we1    = pop1 && !collide;
    assign bus.waddr1 = (count >= CW'(1)) ? rd_q[rptr]   : '0;
    assign bus.wdata1 = (count >= CW'(1)) ? data_q[rptr] : '0;
    assign bus.we2    = pop2;
    assign bus.waddr2 = (count >= CW'(2)) ? rd_q[rptr1]   : '0;
    assign bus.wdata2 = (count >= CW'(2)) ? data_q[rptr1] : '0;

    for (genvar j = 0; j < DEPTH; j++) begin : g_occ
        logic [PW-1:0] age;
        assign age    = PW'(j) - rptr;
        assign occ[j] = {1'b0, age} < count;
    end

    // Entry storage is left uninitialised; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push0) begin
            rd_q[wptr]   <= bus.in0_rd;
            data_q[wptr] <= bus.in0_data;
        end
        if (push1) begin
            if (push0) begin
                rd_q[wptr1]   <= bus.in1_rd;
                data_q[wptr1] <= bus.in1_data;
            end else begin
                rd_q[wptr]   <= bus.in1_rd;
                data_q[wptr] <= bus.in1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(npush);
            rptr  <= rptr + PW'(npop);
            count <= count + CW'(npush) - CW'(npop);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_byp
        wb_bypass_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_lookup (
            .occ    (occ),
            .rd_q   (rd_q),
            .data_q (data_q),
            .head   (rptr),
            .raddr  (bus.raddr[k*AW +: AW]),
            .hit    (bus.byp_hit[k]),
            .data   (bus.byp_data[k*XLEN +: XLEN])
        );
    end
endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: expected register-file writes are queued by the
// stimulus and consumed by a monitor; an XOR-banked register file model sits behind.
module tb_wb_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wb_buffer_if #(.XLEN(32), .AW(5)) bus ();

    wb_buffer #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          port;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] rf [32] = '{default: '0};

    // Same-address dual writes corrupt the banked file into the XOR of both values.
    always @(posedge clk) begin
        if (bus.we1 && bus.we2 && bus.waddr1 == bus.waddr2) begin
            if (bus.waddr1 != 5'd0) rf[bus.waddr1] <= bus.wdata1 ^ bus.wdata2;
        end else begin
            if (bus.we1 && bus.waddr1 != 5'd0) rf[bus.waddr1] <= bus.wdata1;
            if (bus.we2 && bus.waddr2 != 5'd0) rf[bus.waddr2] <= bus.wdata2;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_wr(input int port, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: port%0d x%0d=0x%0h with nothing expected", port, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.port != port || e.addr != a || e.data != d) begin
                n_fail++;
                $display("FAIL write_order: got port%0d x%0d=0x%0h expected port%0d x%0d=0x%0h",
                         port, a, d, e.port, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.we1) chk_wr(1, bus.waddr1, bus.wdata1);
        if (bus.we2) chk_wr(2, bus.waddr2, bus.wdata2);
        if (bus.we1 && bus.we2) check("dual_addr_distinct", 64'(bus.waddr1 != bus.waddr2), 64'd1);
    end

    function automatic void expect_wr(input int port, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.port = port;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic logic [19:0] ra(input logic [4:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        bus.in0_valid = v0; bus.in0_rd = r0; bus.in0_data = d0;
        bus.in1_valid = v1; bus.in1_rd = r1; bus.in1_data = d1;
        cyc();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    initial begin
        bus.in0_valid = 1'b0; bus.in0_rd = '0; bus.in0_data = '0;
        bus.in1_valid = 1'b0; bus.in1_rd = '0; bus.in1_data = '0;
        bus.wb_hold   = 1'b0;
        bus.raddr     = '0;

        repeat (2) cyc();
        check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_we", 64'({bus.we1, bus.we2}), 64'd0);
        check("rst_waddr_wdata", {27'd0, bus.waddr1, bus.wdata1}, 64'd0);
        check("rst_byp_hit", 64'(bus.byp_hit), 64'd0);
        check("rst_byp_data", 64'(bus.byp_data[63:0]), 64'd0);

        // Basic pair
        expect_wr(1, 5'd5, 32'h11);
        expect_wr(2, 5'd6, 32'h22);
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
        bus.raddr = ra(5'd5, 5'd6, 5'd0, 5'd0);
        #1;
        check("pair_byp_hit", 64'(bus.byp_hit), 64'b0011);
        check("pair_byp_d0", 64'(bus.byp_data[31:0]), 64'h11);
        check("pair_byp_d1", 64'(bus.byp_data[63:32]), 64'h22);
        cyc();
        check("pair_rf_x5", 64'(rf[5]), 64'h11);
        check("pair_rf_x6", 64'(rf[6]), 64'h22);
        check("pair_byp_cleared", 64'(bus.byp_hit), 64'd0);

        // Same-address pair
        expect_wr(2, 5'd7, 32'hBB);
        drive(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
        bus.raddr = ra(5'd7, 5'd0, 5'd0, 5'd0);
        #1;
        check("coll_byp_newest", 64'(bus.byp_data[31:0]), 64'hBB);
        check("coll_we1", 64'(bus.we1), 64'd0);
        cyc();
        check("coll_rf_x7", 64'(rf[7]), 64'hBB);

        // x0 lane dropped
        expect_wr(1, 5'd3, 32'h33);
        drive(1'b1, 5'd0, 32'hFF, 1'b1, 5'd3, 32'h33);
        bus.raddr = ra(5'd0, 5'd3, 5'd0, 5'd0);
        #1;
        check("x0_byp_hit", 64'(bus.byp_hit), 64'b0010);
        check("x0_we1", 64'(bus.we1), 64'd1);
        check("x0_we2", 64'(bus.we2), 64'd0);
        cyc();
        check("x0_rf_x3", 64'(rf[3]), 64'h33);
        check("x0_rf_x0", 64'(rf[0]), 64'd0);

        // Hold, fill to DEPTH, bypass, then drain with wrap
        bus.wb_hold = 1'b1;
        drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC);
        check("hold_ready_cnt2", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 5'd9, 32'h2, 1'b1, 5'd13, 32'hD);
        check("hold_ready_full", 64'(bus.in_ready), 64'd0);
        check("hold_no_we", 64'({bus.we1, bus.we2}), 64'd0);
        bus.raddr = ra(5'd10, 5'd12, 5'd9, 5'd0);
        #1;
        check("byp_hits", 64'(bus.byp_hit), 64'b0110);
        check("byp_lane1", 64'(bus.byp_data[63:32]), 64'hC);
        check("byp_lane2_newest", 64'(bus.byp_data[95:64]), 64'h2);
        drive(1'b1, 5'd14, 32'hE, 1'b1, 5'd15, 32'hF);
        check("full_still_blocked", 64'(bus.in_ready), 64'd0);
        expect_wr(1, 5'd9, 32'h1);
        expect_wr(2, 5'd12, 32'hC);
        expect_wr(1, 5'd9, 32'h2);
        expect_wr(2, 5'd13, 32'hD);
        bus.wb_hold = 1'b0;
        cyc();
        check("drain_ready_cnt2", 64'(bus.in_ready), 64'd1);
        cyc();
        check("drain_rf_x9", 64'(rf[9]), 64'h2);
        check("drain_rf_x12", 64'(rf[12]), 64'hC);
        check("drain_rf_x13", 64'(rf[13]), 64'hD);
        check("ignored_rf_x14_x15", {rf[14], rf[15]}, 64'd0);

        // Reset with three entries held, plus a push in the reset cycle
        bus.wb_hold = 1'b1;
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
        drive(1'b1, 5'd22, 32'h22, 1'b0, 5'd0, 32'h0);
        check("cnt3_ready", 64'(bus.in_ready), 64'd0);
        bus.raddr = ra(5'd0, 5'd0, 5'd0, 5'd22);
        #1;
        check("cnt3_byp_hit", 64'(bus.byp_hit), 64'b1000);
        rst = 1'b1;
        bus.wb_hold = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_rd = 5'd23; bus.in0_data = 32'h23;
        #1;
        check("rst_mid_we", 64'({bus.we1, bus.we2}), 64'd0);
        cyc();
        rst = 1'b0;
        bus.in0_valid = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_byp_hit", 64'(bus.byp_hit), 64'd0);
        check("post_rst_byp_data", 64'(bus.byp_data[127:96]), 64'd0);
        repeat (3) cyc();
        check("post_rst_rf_x20_x21", {rf[20], rf[21]}, 64'd0);
        check("post_rst_rf_x22_x23", {rf[22], rf[23]}, 64'd0);

        expect_wr(1, 5'd24, 32'h24);
        drive(1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'h0);
        cyc();
        check("post_rst_rf_x24", 64'(rf[24]), 64'h24);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
